// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the register write-port arbiter.
// Latency: none (definitions only).
// Backpressure: n/a.
package reg_write_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Index width for n requesters; at least one bit so a 1-bit owner field stays legal.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Rotate-priority encoder: first set bit of mask at or after ptr, wrapping at N.
// Latency: purely combinational.
// Backpressure: none; caller qualifies the mask.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] ptr,
    output logic             vld,
    output logic [IDX_W-1:0] idx
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        vld      = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!vld && mask[cand_idx]) begin
                vld = 1'b1;
                idx = cand_idx;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for one shared register write port, with bounded locking.
// Latency: arbitration combinational in cycle t; grant and write strobe registered, seen in t+1.
// Backpressure: req_i held until its gnt_o pulse; a just-granted requester sits out one cycle.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 21,
    parameter int LOCK_MAX = 8,
    localparam int IDX_W   = idx_width(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ-1:0]        clr_i,
    input  logic [N_REQ-1:0]        lock_i,
    input  logic [N_REQ*DATA_W-1:0] data_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic                    reg_e_o,
    output logic                    reg_r_o,
    output logic [DATA_W-1:0]       reg_d_o,
    output logic [IDX_W-1:0]        owner_o,
    output logic                    locked_o
);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q;
    logic [7:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  owner_q;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              reg_e_q, reg_r_q;
    logic [DATA_W-1:0] reg_d_q;

    logic [N_REQ-1:0]  owner_oh;
    logic [N_REQ-1:0]  elig;
    logic              forced;
    logic              grant;
    logic              win_vld;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  ptr_next;
    logic [DATA_W-1:0] win_dat;

    // Once the lock budget is spent the owner competes under plain round-robin rules.
    assign forced = (state_q == LOCKED) && (cnt_q >= 8'(LOCK_MAX));

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
        elig              = req_i & ~gnt_q;
        if (state_q == LOCKED && !forced) begin
            elig = elig & owner_oh;
        end
    end

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .mask (elig),
        .ptr  (ptr_q),
        .vld  (win_vld),
        .idx  (win_idx)
    );

    always_comb begin
        win_dat = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (IDX_W'(k) == win_idx) begin
                win_dat = data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_next = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        gnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    grant = 1'b1;
                    if (lock_i[win_idx]) begin
                        state_d = LOCKED;
                        cnt_d   = 8'd1;
                    end
                end
            end
            LOCKED: begin
                if (forced) begin
                    if (win_vld) begin
                        grant   = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (win_vld) begin
                    grant = 1'b1;
                    if (lock_i[owner_q]) begin
                        cnt_d = cnt_q + 8'd1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (!req_i[owner_q] && !lock_i[owner_q]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (grant) begin
            gnt_d[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            reg_e_q <= 1'b0;
            reg_r_q <= 1'b0;
            reg_d_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            if (grant) begin
                ptr_q   <= ptr_next;
                owner_q <= win_idx;
                reg_r_q <= clr_i[win_idx];
                reg_e_q <= !clr_i[win_idx];
                if (!clr_i[win_idx]) begin
                    reg_d_q <= win_dat;
                end
            end else begin
                reg_e_q <= 1'b0;
                reg_r_q <= 1'b0;
            end
        end
    end

    assign gnt_o    = gnt_q;
    assign reg_e_o  = reg_e_q;
    assign reg_r_o  = reg_r_q;
    assign reg_d_o  = reg_d_q;
    assign owner_o  = owner_q;
    assign locked_o = (state_q == LOCKED);

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of one register (data_e/data_r/data_d of the team's register primitive) between N_REQ requesters.
- Each cycle it selects at most one pending requester and drives one registered write or clear strobe into the register.
- It acknowledges the winner with a one-cycle grant.
- Supports bounded exclusive locking so a requester can perform back-to-back updates without interleaving.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 21, register data width; matches the shared register.
- LOCK_MAX, 8, maximum consecutive grants to a locked owner before forced release (1..255).
- IDX_W, $clog2(N_REQ), localparam; owner index width.

Ports:
- clk_i  in  1  clock, all logic on posedge.
- rst_n_i  in  1  reset, synchronous and active-low.
- req_i  in  N_REQ  per-requester write request; held until its gnt_o bit pulses.
- clr_i  in  N_REQ  per-requester qualifier: request is a clear to reset value, not a data write.
- lock_i  in  N_REQ  per-requester lock request, sampled together with req_i.
- data_i  in  N_REQ*DATA_W  packed write data; requester k at bits [k*DATA_W +: DATA_W].
- gnt_o  out  N_REQ  one-hot grant pulse; the request is consumed in this cycle.
- reg_e_o  out  1  write enable to shared register (drives data_e).
- reg_r_o  out  1  clear strobe to shared register (drives data_r).
- reg_d_o  out  DATA_W  write data to shared register (drives data_d).
- owner_o  out  IDX_W  index of the last granted / current lock owner.
- locked_o  out  1  high while in LOCKED state.

Behaviour:
- Reset (rst_n_i low at posedge):
  - gnt_o=0, reg_e_o=0, reg_r_o=0, reg_d_o=0, owner_o=0, locked_o=0.
  - Priority pointer ptr=0; lock counter cnt=0; state IDLE.
  - Reset mid-lock drops the lock immediately. No grant is issued in the reset cycle.
- Latency and registering:
  - Arbitration on cycle t is combinational from req_i and state.
  - gnt_o, reg_e_o, reg_r_o, reg_d_o and owner_o are registered and visible in cycle t+1. Grant and write strobe are coincident.
- Busy window:
  - A requester whose gnt_o bit is high in cycle t+1 is excluded from arbitration in t+1, so a held req_i is not double-granted.
  - The requester deasserts req_i or presents new data in t+2.
  - Effective throughput is one grant per cycle across different requesters, and one grant per 2 cycles for the same requester.
- State machine:
  - IDLE:
    - Round-robin search starting at ptr over eligible requesters (req_i high, not masked).
    - On winner w: gnt_o[w]=1; ptr <= (w+1) mod N_REQ; owner_o <= w.
    - If lock_i[w]=1 on that cycle, go to LOCKED with cnt=1.
  - LOCKED:
    - Only the owner is eligible; all other requests wait.
    - An owner request with lock_i high grants and increments cnt.
    - An owner request with lock_i low grants that last write, then returns to IDLE.
    - Owner req_i low with lock_i low: return to IDLE with no grant.
    - If cnt reaches LOCK_MAX, the next arbitration is forced to IDLE rules, lock_i is ignored for one win, and cnt clears. This guarantees starvation freedom.
- Write encoding:
  - clr_i[w]=1 gives reg_r_o=1, reg_e_o=0, reg_d_o unchanged.
  - Otherwise reg_e_o=1, reg_d_o=data_i[w].
  - reg_e_o and reg_r_o are never both high.
  - With no grant, both are 0 and reg_d_o holds its last value.
- Boundaries:
  - Single requester: granted every other cycle.
  - All requesters pending: grant order ptr, ptr+1, ... with wrap from N_REQ-1 to 0.
  - Simultaneous clr_i and lock_i: the clear takes effect and the lock is honoured.

Decomposition:
- Shared package: state enum {IDLE, LOCKED}; the function deriving IDX_W from N_REQ.
- One sub-module, rr_pick: combinational rotate-priority encoder taking (mask vector, ptr) and returning (valid, index). It is reusable by other arbiters.
- All sequential logic stays in reg_write_arbiter.

Test Plan (N_REQ=4, DATA_W=21, LOCK_MAX=3):
- After reset, req_i=4'b1111 with data_i[k]=k+1, held: grants occur in order 0,1,2,3,0. reg_d_o sequence is 1,2,3,4,1, and reg_e_o is high on each grant cycle.
- req_i=4'b0100 held continuously: gnt_o=4'b0100 every other cycle. owner_o=2. No double grant on back-to-back cycles.
- Requester 1 with req_i and lock_i high and data 0x10, requester 3 also pending: 3 grants to 1 occur. Then the forced release grants 3 before 1 is granted again. locked_o is high during the lock run.
- Requester 0 with clr_i=1 and req_i=1: reg_r_o=1 and reg_e_o=0 on the grant cycle, and reg_d_o is unchanged.
- rst_n_i pulled low for 1 cycle while LOCKED with cnt=2: all outputs reach reset values at that posedge. The next arbitration starts at ptr=0.
- req_i=0 for 10 cycles: gnt_o, reg_e_o and reg_r_o stay 0, and reg_d_o holds its value.
